// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the multicycle PC sequencer and related datapath blocks.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_EXEC,
        ST_COMMIT,
        ST_HALTED,
        ST_ERROR
    } state_t;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP      = 4;
    localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory handshake and execute/branch signals between the sequencer and the datapath.
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        branch;
    logic        zero;
    logic [31:0] branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid,
        input  imem_ack, exec_done, branch, zero, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid,
        output imem_ack, exec_done, branch, zero, branch_target
    );

endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next-PC selection: sequential step or branch target; purely combinational, wraps modulo 2^32.
module pc_next_sel #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_target,
    input  logic        i_taken,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc + 32'(PC_STEP);
        if (i_taken) begin
            o_next_pc = i_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: fetch / execute-wait / commit sequencing with halt, timeout and alignment checks.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    pc_sequencer_if.master     bus,
    output logic [31:0]        pc,
    output logic               pc_write,
    output logic [CNT_W-1:0]   taken_count,
    output logic               halted,
    output logic               error,
    output logic               busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_pc;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_halt;
    logic               r_branch;
    logic               r_zero;
    logic [31:0]        r_target;
    logic [CNT_W-1:0]   r_taken_count;
    logic               r_instr_valid;
    logic               r_pc_write;

    logic               w_taken;
    logic               w_misaligned;
    logic               w_commit_ok;
    logic               w_tmo_expire;
    logic [31:0]        w_next_pc;

    pc_next_sel #(
        .PC_STEP (PC_STEP)
    ) u_next_sel (
        .i_pc      (r_pc),
        .i_target  (r_target),
        .i_taken   (w_taken),
        .o_next_pc (w_next_pc)
    );

    always_comb begin
        w_next_state = r_state;
        w_taken      = r_branch & r_zero;
        w_misaligned = w_taken && ((r_target[1:0] & INSTR_ALIGN_MASK) != 2'b00);
        w_commit_ok  = (r_state == ST_COMMIT) && !w_misaligned;
        w_tmo_expire = (r_tmo == TMO_W'(TIMEOUT - 1));

        unique case (r_state)
            ST_IDLE: begin
                if (r_halt || halt_req) begin
                    w_next_state = ST_HALTED;
                end else if (start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // ack on the expiring cycle still wins over the timeout
                if (bus.imem_ack) begin
                    w_next_state = ST_WAIT_EXEC;
                end else if (w_tmo_expire) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_WAIT_EXEC: begin
                if (bus.exec_done) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (w_misaligned) begin
                    w_next_state = ST_ERROR;
                end else if (r_halt) begin
                    w_next_state = ST_HALTED;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALTED: w_next_state = ST_HALTED;
            ST_ERROR:  w_next_state = ST_ERROR;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_tmo         <= '0;
            r_halt        <= 1'b0;
            r_branch      <= 1'b0;
            r_zero        <= 1'b0;
            r_target      <= '0;
            r_taken_count <= '0;
            r_instr_valid <= 1'b0;
            r_pc_write    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_halt        <= r_halt | halt_req;
            r_instr_valid <= (r_state == ST_FETCH) && bus.imem_ack;
            r_pc_write    <= w_commit_ok;

            if (r_state == ST_FETCH) begin
                if (bus.imem_ack) begin
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end

            if ((r_state == ST_WAIT_EXEC) && bus.exec_done) begin
                r_branch <= bus.branch;
                r_zero   <= bus.zero;
                r_target <= bus.branch_target;
            end

            if (w_commit_ok) begin
                r_pc <= w_next_pc;
                if (w_taken && (r_taken_count != '1)) begin
                    r_taken_count <= r_taken_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.imem_req    = (r_state == ST_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign pc              = r_pc;
    assign pc_write        = r_pc_write;
    assign taken_count     = r_taken_count;
    assign halted          = (r_state == ST_HALTED);
    assign error           = (r_state == ST_ERROR);
    assign busy            = (r_state == ST_FETCH) || (r_state == ST_WAIT_EXEC) || (r_state == ST_COMMIT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction-level reference model driven with randomized handshake timing.
module tb_pc_sequencer;

    localparam int unsigned TMO     = 4;
    localparam int unsigned CW      = 2;
    localparam int unsigned CNT_MAX = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          halt_req;
    logic [31:0]   pc;
    logic          pc_write;
    logic [CW-1:0] taken_count;
    logic          halted;
    logic          error;
    logic          busy;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4),
        .TIMEOUT  (TMO),
        .CNT_W    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .bus         (bus),
        .pc          (pc),
        .pc_write    (pc_write),
        .taken_count (taken_count),
        .halted      (halted),
        .error       (error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    int unsigned m_cnt;
    bit          m_halt;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic junk_inputs();
        bus.branch        = 1'($urandom);
        bus.zero          = 1'($urandom);
        bus.branch_target = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset             = 1'b1;
        start             = 1'b0;
        halt_req          = 1'b0;
        bus.imem_ack      = 1'b0;
        bus.exec_done     = 1'b0;
        bus.branch        = 1'b0;
        bus.zero          = 1'b0;
        bus.branch_target = '0;
        tick();
        reset  = 1'b0;
        m_pc   = 32'h0;
        m_cnt  = 0;
        m_halt = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({bus.imem_req, busy, halted, error} !== 4'b1100) begin
            errors++;
            $display("FAIL start_fetch: got %b expected 1100", {bus.imem_req, busy, halted, error});
        end
    endtask

    // One complete instruction: d stalled FETCH cycles, e stalled WAIT_EXEC cycles.
    task automatic do_instr(input int unsigned d, input int unsigned e, input bit br, input bit z,
                            input logic [31:0] tgt, input bit halt_in_wait);
        logic [31:0]   e_pc;
        logic [CW-1:0] e_cnt;
        bit            taken;
        bit            bad;
        for (int unsigned i = 0; i <= d; i++) begin
            checks++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, m_pc}) begin
                errors++;
                $display("FAIL fetch_req: got %b/%h expected 1/%h", bus.imem_req, bus.imem_addr, m_pc);
            end
            bus.imem_ack  = (i == d);
            bus.exec_done = 1'($urandom);
            junk_inputs();
            tick();
        end
        bus.imem_ack = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.imem_req, busy} !== 3'b101) begin
            errors++;
            $display("FAIL instr_valid: got %b expected 101", {bus.instr_valid, bus.imem_req, busy});
        end
        if (halt_in_wait) begin
            halt_req = 1'b1;
            m_halt   = 1'b1;
        end
        for (int unsigned i = 0; i < e; i++) begin
            bus.exec_done = 1'b0;
            bus.imem_ack  = 1'($urandom);
            junk_inputs();
            tick();
            halt_req = 1'b0;
            checks++;
            if ({bus.instr_valid, bus.imem_req, busy} !== 3'b001) begin
                errors++;
                $display("FAIL wait_exec: got %b expected 001", {bus.instr_valid, bus.imem_req, busy});
            end
        end
        bus.exec_done     = 1'b1;
        bus.imem_ack      = 1'($urandom);
        bus.branch        = br;
        bus.zero          = z;
        bus.branch_target = tgt;
        tick();
        halt_req      = 1'b0;
        bus.exec_done = 1'b0;
        bus.imem_ack  = 1'($urandom);
        junk_inputs();
        checks++;
        if ({busy, pc_write, pc} !== {1'b1, 1'b0, m_pc}) begin
            errors++;
            $display("FAIL commit: got %b/%b/%h expected 1/0/%h", busy, pc_write, pc, m_pc);
        end
        tick();
        bus.imem_ack = 1'b0;

        taken = br && z;
        bad   = taken && (tgt % 4 != 0);
        if (bad) begin
            e_pc  = m_pc;
            e_cnt = CW'(m_cnt);
            checks++;
            if ({pc, pc_write, taken_count, bus.imem_req, halted, error, busy} !== {e_pc, 1'b0, e_cnt, 4'b0010}) begin
                errors++;
                $display("FAIL misaligned: got pc=%h pw=%b cnt=%0d req=%b h=%b err=%b busy=%b expected pc=%h pw=0 cnt=%0d err=1",
                         pc, pc_write, taken_count, bus.imem_req, halted, error, busy, e_pc, e_cnt);
            end
        end else begin
            m_pc  = taken ? tgt : m_pc + 32'd4;
            if (taken && m_cnt < CNT_MAX) m_cnt++;
            e_cnt = CW'(m_cnt);
            checks++;
            if ({pc, pc_write, taken_count, bus.imem_req, halted, error} !==
                {m_pc, 1'b1, e_cnt, !m_halt, m_halt, 1'b0}) begin
                errors++;
                $display("FAIL next_pc: got pc=%h pw=%b cnt=%0d req=%b h=%b err=%b expected pc=%h pw=1 cnt=%0d req=%b h=%b err=0",
                         pc, pc_write, taken_count, bus.imem_req, halted, error, m_pc, e_cnt, !m_halt, m_halt);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, pc_write, taken_count, bus.imem_req, bus.instr_valid, halted, error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h pw=%b cnt=%0d req=%b iv=%b h=%b err=%b busy=%b expected all 0",
                     pc, pc_write, taken_count, bus.imem_req, bus.instr_valid, halted, error, busy);
        end
        bus.imem_ack  = 1'b1;
        bus.exec_done = 1'b1;
        repeat (3) tick();
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        checks++;
        if ({busy, bus.imem_req, pc_write, pc} !== '0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b req=%b pw=%b pc=%h expected 0/0/0/0", busy, bus.imem_req, pc_write, pc);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        begin_run();
        do_instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_instr(0, 0, 1'b0, 1'b1, 32'h80, 1'b0);
        do_instr(0, 0, 1'b1, 1'b1, 32'h40, 1'b0);
        do_instr(0, 0, 1'b1, 1'b0, 32'h100, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        begin_run();
        for (int unsigned i = 0; i < TMO; i++) begin
            checks++;
            if ({bus.imem_req, error} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait: cycle %0d got req=%b err=%b expected 1/0", i, bus.imem_req, error);
            end
            bus.imem_ack  = 1'b0;
            bus.exec_done = 1'b1;
            tick();
        end
        bus.exec_done = 1'b0;
        checks++;
        if ({bus.imem_req, busy, error, pc} !== {3'b001, m_pc}) begin
            errors++;
            $display("FAIL timeout_err: got req=%b busy=%b err=%b pc=%h expected 0/0/1/%h", bus.imem_req, busy, error, pc, m_pc);
        end
        start        = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (3) tick();
        start        = 1'b0;
        bus.imem_ack = 1'b0;
        checks++;
        if ({bus.imem_req, error, pc_write} !== 3'b010) begin
            errors++;
            $display("FAIL error_sticky: got req=%b err=%b pw=%b expected 0/1/0", bus.imem_req, error, pc_write);
        end
        do_reset();
        begin_run();
        do_instr(TMO - 1, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_instr(TMO - 1, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_halt();
        do_reset();
        begin_run();
        do_instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_instr(1, 2, 1'b1, 1'b1, 32'h20, 1'b1);
        start        = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (4) tick();
        start        = 1'b0;
        bus.imem_ack = 1'b0;
        checks++;
        if ({bus.imem_req, halted, pc_write, pc} !== {3'b010, m_pc}) begin
            errors++;
            $display("FAIL halt_sticky: got req=%b h=%b pw=%b pc=%h expected 0/1/0/%h", bus.imem_req, halted, pc_write, pc, m_pc);
        end
        do_reset();
        halt_req = 1'b1;
        start    = 1'b1;
        tick();
        halt_req = 1'b0;
        start    = 1'b0;
        checks++;
        if ({bus.imem_req, halted, busy} !== 3'b010) begin
            errors++;
            $display("FAIL idle_halt: got req=%b h=%b busy=%b expected 0/1/0", bus.imem_req, halted, busy);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        begin_run();
        do_instr(0, 0, 1'b1, 1'b0, 32'h42, 1'b0);
        do_instr(0, 0, 1'b1, 1'b1, 32'h40, 1'b0);
        do_instr(1, 1, 1'b1, 1'b1, 32'h42, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        begin_run();
        do_instr(0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        do_instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        begin_run();
        for (int unsigned i = 0; i < CNT_MAX + 2; i++) begin
            do_instr(0, 0, 1'b1, 1'b1, 32'h100 + 32'(i * 16), 1'b0);
        end
        do_instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fetch: got req=%b expected 1", bus.imem_req);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, pc, taken_count, busy, pc_write, bus.instr_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got req=%b pc=%h cnt=%0d busy=%b pw=%b iv=%b expected all 0",
                     bus.imem_req, pc, taken_count, busy, pc_write, bus.instr_valid);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, bus.imem_req, halted, error} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b req=%b h=%b err=%b expected 0000", busy, bus.imem_req, halted, error);
        end
        m_pc  = 32'h0;
        m_cnt = 0;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        begin_run();
        for (int unsigned n = 0; n < 60; n++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            do_instr($urandom_range(0, TMO - 1), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_sequential();
        test_timeout();
        test_halt();
        test_misaligned();
        test_wrap();
        test_saturation_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle program-counter controller for the RISC-V datapath.
- Owns the PC register and sequences each instruction through fetch, execute-wait and commit.
- Selects next PC as PC+4 or the branch target using the branch AND zero condition.
- Handles instruction-memory handshake, halt requests, fetch timeout and misaligned-target errors, and keeps a taken-branch statistics counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- TIMEOUT, 255, max FETCH cycles without imem_ack before ERROR; must be ≥1.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; leaves IDLE and begins fetching.
- halt_req  in  1  pulse or level; captured into a sticky flag.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  fetch complete.
- instr_valid  out  1  one-cycle pulse, fetched instruction ready for decode.
- exec_done  in  1  datapath has finished executing the current instruction.
- branch  in  1  branch signal from control.
- zero  in  1  ALU zero flag.
- branch_target  in  32  PC+offset from the shift adder.
- pc  out  32  current PC.
- pc_write  out  1  one-cycle pulse on each PC update.
- taken_count  out  CNT_W  count of committed taken branches.
- halted  out  1  high in HALTED.
- error  out  1  high in ERROR.
- busy  out  1  high in FETCH, WAIT_EXEC and COMMIT.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - Outputs: pc=RESET_PC, state=IDLE, taken_count=0, timeout counter=0, halt flag=0; all other outputs 0.
  - Any in-flight fetch is abandoned. imem_req drops immediately.
- States: IDLE, FETCH, WAIT_EXEC, COMMIT, HALTED, ERROR.
- IDLE:
  - halt flag or halt_req → HALTED. This has priority over start.
  - Otherwise start=1 → FETCH.
- FETCH:
  - Drive imem_req=1 and imem_addr=pc.
  - imem_ack=1 → pulse instr_valid next cycle, clear timeout counter, go to WAIT_EXEC.
  - Without ack, increment timeout counter. When it reaches TIMEOUT → ERROR.
  - If ack arrives in the same cycle the counter would expire, ack wins.
- WAIT_EXEC:
  - imem_req=0.
  - On exec_done=1, register branch, zero and branch_target, then go to COMMIT.
- COMMIT (exactly 1 cycle):
  - taken = branch & zero (registered values).
  - taken and branch_target[1:0]≠0 → ERROR. pc unchanged, no pc_write.
  - Otherwise: pc ← taken ? target : pc+PC_STEP, pulse pc_write, increment taken_count if taken.
  - taken_count saturates at all-ones.
  - Next state: HALTED if the halt flag is set, else FETCH.
- HALTED and ERROR are terminal; only reset exits them.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Input gating:
  - imem_ack is ignored outside FETCH.
  - exec_done is ignored outside WAIT_EXEC.
  - branch, zero and branch_target are sampled only on the exec_done cycle.
- Halt:
  - halt_req in any state sets the sticky halt flag.
  - The flag is honoured only at the COMMIT boundary or in IDLE, so an instruction in flight always completes.
- Latency:
  - Minimum 3 cycles per instruction, when ack arrives in the first FETCH cycle and exec_done arrives in the first WAIT_EXEC cycle.
  - The new pc is visible the cycle after COMMIT, coinciding with the next imem_req.
- Outputs are registered or decoded from state only; no input-to-output combinational paths.

Decomposition:
- Shared package holds:
  - state enum (3-bit encoding),
  - RESET_PC default,
  - PC_STEP,
  - the INSTR_ALIGN_MASK constant (2'b11).
- Sub-module pc_next_sel: combinational selection of pc+PC_STEP or target from taken. It replaces the ad-hoc next-PC mux and is reusable by the pipelined datapath.

Test Plan:
- Reset with RESET_PC=0, start=1, ack and exec_done immediate, branch=0 → pc=0,4,8 on successive pc_write pulses 3 cycles apart; taken_count=0.
- At pc=8, exec_done with branch=1, zero=1, target=32'h40 → pc=32'h40 after COMMIT; taken_count=1. Same with zero=0 → pc=32'hC.
- Withhold imem_ack with TIMEOUT=4 → error=1 after 4 FETCH cycles; pc unchanged. Second case: ack on the 4th cycle → no error.
- halt_req pulse during WAIT_EXEC → current instruction commits (pc_write seen), then halted=1, no further imem_req.
- Taken branch to 32'h42 → error=1, pc unchanged, taken_count unchanged. pc=32'hFFFF_FFFC sequential → pc=0.
- Assert reset mid-FETCH with imem_req=1 → imem_req=0 immediately (async), pc=RESET_PC, state IDLE; preload taken_count near saturation and verify no wrap.
